// File: rtl/processor.sv
// Single-cycle 32-bit MIPS subset: controller + datapath core, instruction ROM and data RAM.
// One instruction retires per rising clk edge; state is visible only through the register file.

package processor_pkg;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLTU, ALU_SLT, ALU_LUI} alu_op_t;
    typedef enum logic [2:0] {RES_ALU, RES_MEM, RES_HI, RES_LO, RES_PC4} res_sel_t;
    typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_sel_t;

    typedef struct packed {
        logic     reg_write;
        dst_sel_t dst;
        logic     alu_src_imm;
        logic     zero_ext;
        alu_op_t  alu;
        logic     mem_write;
        res_sel_t res;
        logic     branch_eq;
        logic     branch_ne;
        logic     jump;
        logic     jump_reg;
        logic     hilo_write;
        logic     mult_signed;
    } ctrl_t;
endpackage

module controller
    import processor_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        case (op)
            6'h00: begin
                // ALU decoder: R-type behaviour is selected by funct
                ctrl.dst = DST_RD;
                case (funct)
                    6'h21: begin ctrl.reg_write = 1'b1; ctrl.alu = ALU_ADD;  end
                    6'h23: begin ctrl.reg_write = 1'b1; ctrl.alu = ALU_SUB;  end
                    6'h24: begin ctrl.reg_write = 1'b1; ctrl.alu = ALU_AND;  end
                    6'h25: begin ctrl.reg_write = 1'b1; ctrl.alu = ALU_OR;   end
                    6'h2B: begin ctrl.reg_write = 1'b1; ctrl.alu = ALU_SLTU; end
                    6'h08: ctrl.jump_reg = 1'b1;
                    6'h18: begin ctrl.hilo_write = 1'b1; ctrl.mult_signed = 1'b1; end
                    6'h19: ctrl.hilo_write = 1'b1;
                    6'h10: begin ctrl.reg_write = 1'b1; ctrl.res = RES_HI; end
                    6'h12: begin ctrl.reg_write = 1'b1; ctrl.res = RES_LO; end
                    default: ctrl.dst = DST_RT;
                endcase
            end
            6'h08, 6'h09: begin ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu = ALU_ADD; end
            6'h0C: begin ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.zero_ext = 1'b1; ctrl.alu = ALU_AND; end
            6'h0D: begin ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.zero_ext = 1'b1; ctrl.alu = ALU_OR; end
            6'h0F: begin ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu = ALU_LUI; end
            6'h0A: begin ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu = ALU_SLT; end
            6'h0B: begin ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu = ALU_SLTU; end
            6'h23: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.res         = RES_MEM;
            end
            6'h2B: begin ctrl.mem_write = 1'b1; ctrl.alu_src_imm = 1'b1; end
            6'h04: begin ctrl.branch_eq = 1'b1; ctrl.alu = ALU_SUB; end
            6'h05: begin ctrl.branch_ne = 1'b1; ctrl.alu = ALU_SUB; end
            6'h02: ctrl.jump = 1'b1;
            6'h03: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.dst       = DST_RA;
                ctrl.res       = RES_PC4;
            end
            default: ;
        endcase
    end
endmodule

module regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk) begin
        if (we && wa != 5'd0)
            registers[wa] <= wd;
    end

    // $0 is hardwired; its storage word is never consulted
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

module datapath
    import processor_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  ctrl_t       ctrl,
    input  logic [25:0] instr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we
);
    logic [31:0] pc_reg, pc_next, pc_plus4, branch_target;
    logic [31:0] hi_reg, lo_reg;
    logic [31:0] rd1, rd2, imm_ext, src_b, alu_result, result;
    logic [63:0] product;
    logic [4:0]  write_addr;
    logic        zero, reg_we;

    regfile gpr (
        .clk (clk),
        .we  (reg_we),
        .ra1 (instr[25:21]),
        .ra2 (instr[20:16]),
        .wa  (write_addr),
        .wd  (result),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    assign imm_ext = ctrl.zero_ext ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    assign src_b   = ctrl.alu_src_imm ? imm_ext : rd2;

    always_comb begin
        alu_result = 32'd0;
        case (ctrl.alu)
            ALU_ADD:  alu_result = rd1 + src_b;
            ALU_SUB:  alu_result = rd1 - src_b;
            ALU_AND:  alu_result = rd1 & src_b;
            ALU_OR:   alu_result = rd1 | src_b;
            ALU_SLTU: alu_result = (rd1 < src_b) ? 32'd1 : 32'd0;
            ALU_SLT:  alu_result = ($signed(rd1) < $signed(src_b)) ? 32'd1 : 32'd0;
            ALU_LUI:  alu_result = {src_b[15:0], 16'h0};
            default:  alu_result = 32'd0;
        endcase
    end
    assign zero = (alu_result == 32'd0);

    // Sign-extending both operands to 64 bits yields the exact two's-complement product
    assign product = ctrl.mult_signed ? ({{32{rd1[31]}}, rd1} * {{32{rd2[31]}}, rd2})
                                      : ({32'h0, rd1} * {32'h0, rd2});

    assign pc_plus4      = pc_reg + 32'd4;
    assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};

    always_comb begin
        pc_next = pc_plus4;
        if (ctrl.jump_reg)
            pc_next = rd1;
        else if (ctrl.jump)
            pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if ((ctrl.branch_eq && zero) || (ctrl.branch_ne && !zero))
            pc_next = branch_target;
    end

    always_comb begin
        write_addr = instr[20:16];
        case (ctrl.dst)
            DST_RD:  write_addr = instr[15:11];
            DST_RA:  write_addr = 5'd31;
            default: write_addr = instr[20:16];
        endcase
    end

    always_comb begin
        result = alu_result;
        case (ctrl.res)
            RES_MEM: result = mem_rdata;
            RES_HI:  result = hi_reg;
            RES_LO:  result = lo_reg;
            RES_PC4: result = pc_plus4;
            default: result = alu_result;
        endcase
    end

    assign reg_we    = ctrl.reg_write && !reset;
    assign mem_we    = ctrl.mem_write && !reset;
    assign mem_addr  = alu_result;
    assign mem_wdata = rd2;
    assign pc        = pc_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= RESET_PC;
            hi_reg <= 32'd0;
            lo_reg <= 32'd0;
        end else begin
            pc_reg <= pc_next;
            if (ctrl.hilo_write) begin
                hi_reg <= product[63:32];
                lo_reg <= product[31:0];
            end
        end
    end
endmodule

module mips_core
    import processor_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we
);
    ctrl_t ctrl;

    controller ctl (
        .op    (instr[31:26]),
        .funct (instr[5:0]),
        .ctrl  (ctrl)
    );

    datapath #(.RESET_PC(RESET_PC)) dp (
        .clk       (clk),
        .reset     (reset),
        .ctrl      (ctrl),
        .instr     (instr[25:0]),
        .mem_rdata (mem_rdata),
        .pc        (pc),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we)
    );
endmodule

module instr_rom #(
    parameter int WORDS = 64
) (
    input  logic [31:0] addr,
    output logic [31:0] data
);
    localparam int AW = $clog2(WORDS);

    // Contents are supplied from outside the design (memory load or hierarchical preload)
    logic [31:0] INSTRROM [0:WORDS-1];
    logic        unused_addr_bits;

    assign data             = INSTRROM[addr[AW+1:2]];
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
endmodule

module data_ram #(
    parameter int WORDS = 64
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem [0:WORDS-1];
    logic [AW-1:0] index;
    logic          unused_addr_bits;

    assign index            = addr[AW+1:2];
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

    always_ff @(posedge clk) begin
        if (we)
            mem[index] <= wdata;
    end

    // Loads complete in the same cycle, so the read is asynchronous
    assign rdata = mem[index];
endmodule

module processor #(
    parameter int          IMEM_WORDS = 64,
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input logic clk,
    input logic reset
);
    logic [31:0] pc, instr, mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    mips_core #(.RESET_PC(RESET_PC)) mips (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .mem_rdata (mem_rdata),
        .pc        (pc),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we)
    );

    instr_rom #(.WORDS(IMEM_WORDS)) imem (
        .addr (pc),
        .data (instr)
    );

    data_ram #(.WORDS(DMEM_WORDS)) dmem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );
endmodule

// File: tb/tb_processor.sv
// Bench for processor: directed programs with known results plus random straight-line
// programs checked against an instruction-level reference model.
module tb_processor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #2 clk = ~clk;

    processor dut (
        .clk   (clk),
        .reset (reset)
    );

    localparam logic [31:0] PRE  = 32'hcafebabe;
    localparam logic [31:0] HALT = {6'h04, 5'd0, 5'd0, 16'hffff};   // beq $0,$0,-1

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] prog [64];
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [64];
    logic [31:0] m_hi, m_lo, m_pc;

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    function automatic logic [31:0] gr(input int i);
        return dut.mips.dp.gpr.registers[i];
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    endtask

    // Load ROM and GPRs while reset is high, then release after one reset edge
    task automatic boot(input bit rand_regs);
        logic [31:0] v;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 64; i++) dut.imem.INSTRROM[i] = prog[i];
        m_reg[0] = 32'h0;
        for (int i = 1; i < 32; i++) begin
            v = rand_regs ? $urandom : PRE;
            dut.mips.dp.gpr.registers[i] = v;
            m_reg[i] = v;
        end
        m_hi = 32'h0;
        m_lo = 32'h0;
        m_pc = 32'h0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Architectural reference: executes one instruction from prog[] on the model state
    task automatic model_step();
        logic [31:0] ins, a, b, sx, zx, npc, wv, addr;
        logic [4:0]  wa;
        bit          wr;
        longint      sp;
        longint unsigned up;
        ins  = prog[m_pc[7:2]];
        a    = (ins[25:21] == 5'd0) ? 32'h0 : m_reg[ins[25:21]];
        b    = (ins[20:16] == 5'd0) ? 32'h0 : m_reg[ins[20:16]];
        sx   = {{16{ins[15]}}, ins[15:0]};
        zx   = {16'h0, ins[15:0]};
        npc  = m_pc + 32'd4;
        addr = a + sx;
        wr   = 1'b0;
        wa   = ins[20:16];
        wv   = 32'h0;
        case (ins[31:26])
            6'h00: begin
                wa = ins[15:11];
                case (ins[5:0])
                    6'h21: begin wr = 1'b1; wv = a + b; end
                    6'h23: begin wr = 1'b1; wv = a - b; end
                    6'h24: begin wr = 1'b1; wv = a & b; end
                    6'h25: begin wr = 1'b1; wv = a | b; end
                    6'h2B: begin wr = 1'b1; wv = (a < b) ? 32'd1 : 32'd0; end
                    6'h08: npc = a;
                    6'h18: begin sp = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = sp; end
                    6'h19: begin up = {32'h0, a} * {32'h0, b}; {m_hi, m_lo} = up; end
                    6'h10: begin wr = 1'b1; wv = m_hi; end
                    6'h12: begin wr = 1'b1; wv = m_lo; end
                    default: ;
                endcase
            end
            6'h08, 6'h09: begin wr = 1'b1; wv = a + sx; end
            6'h0C: begin wr = 1'b1; wv = a & zx; end
            6'h0D: begin wr = 1'b1; wv = a | zx; end
            6'h0F: begin wr = 1'b1; wv = {ins[15:0], 16'h0}; end
            6'h0A: begin wr = 1'b1; wv = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; end
            6'h0B: begin wr = 1'b1; wv = (a < sx) ? 32'd1 : 32'd0; end
            6'h23: begin wr = 1'b1; wv = m_mem[addr[7:2]]; end
            6'h2B: m_mem[addr[7:2]] = b;
            6'h04: if (a == b) npc = m_pc + 32'd4 + (sx << 2);
            6'h05: if (a != b) npc = m_pc + 32'd4 + (sx << 2);
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            6'h03: begin wr = 1'b1; wa = 5'd31; wv = m_pc + 32'd4; npc = {npc[31:28], ins[25:0], 2'b00}; end
            default: ;
        endcase
        if (wr && wa != 5'd0) m_reg[wa] = wv;
        m_pc = npc;
    endtask

    task automatic test_alu();
        clear_prog();
        prog[0] = i_ins(6'h0D, 0, 1, 16'd5);
        prog[1] = i_ins(6'h0D, 0, 2, 16'd3);
        prog[2] = r_ins(1, 2, 3, 6'h21);
        prog[3] = r_ins(2, 1, 4, 6'h23);
        prog[4] = r_ins(1, 2, 5, 6'h2B);
        prog[5] = r_ins(2, 1, 6, 6'h2B);
        prog[6] = r_ins(1, 2, 7, 6'h24);
        prog[7] = HALT;
        boot(1'b0);
        run(3);
        n_cmp++; if (gr(1) !== 32'd5) begin n_bad++; $display("FAIL alu_ori_r1: got %h want %h", gr(1), 32'd5); end
        n_cmp++; if (gr(2) !== 32'd3) begin n_bad++; $display("FAIL alu_ori_r2: got %h want %h", gr(2), 32'd3); end
        n_cmp++; if (gr(3) !== 32'd8) begin n_bad++; $display("FAIL alu_addu_r3: got %h want %h", gr(3), 32'd8); end
        n_cmp++; if (gr(4) !== PRE) begin n_bad++; $display("FAIL alu_r4_early: got %h want %h", gr(4), PRE); end
        run(6);
        n_cmp++; if (gr(4) !== 32'hfffffffe) begin n_bad++; $display("FAIL alu_subu_wrap: got %h want %h", gr(4), 32'hfffffffe); end
        n_cmp++; if (gr(5) !== 32'd0) begin n_bad++; $display("FAIL alu_sltu_false: got %h want %h", gr(5), 32'd0); end
        n_cmp++; if (gr(6) !== 32'd1) begin n_bad++; $display("FAIL alu_sltu_true: got %h want %h", gr(6), 32'd1); end
        n_cmp++; if (gr(7) !== 32'd1) begin n_bad++; $display("FAIL alu_and: got %h want %h", gr(7), 32'd1); end
        for (int i = 8; i < 32; i++) begin
            n_cmp++; if (gr(i) !== PRE) begin n_bad++; $display("FAIL alu_untouched r%0d: got %h want %h", i, gr(i), PRE); end
        end
        $display("test_alu done");
    endtask

    task automatic test_lui();
        clear_prog();
        prog[0] = i_ins(6'h0F, 0, 1, 16'h1234);
        prog[1] = i_ins(6'h0D, 1, 1, 16'h5678);
        prog[2] = i_ins(6'h0F, 0, 2, 16'habcd);
        prog[3] = HALT;
        boot(1'b0);
        run(1);
        n_cmp++; if (gr(1) !== 32'h12340000) begin n_bad++; $display("FAIL lui_low_zero: got %h want %h", gr(1), 32'h12340000); end
        run(3);
        n_cmp++; if (gr(1) !== 32'h12345678) begin n_bad++; $display("FAIL lui_ori: got %h want %h", gr(1), 32'h12345678); end
        n_cmp++; if (gr(2) !== 32'habcd0000) begin n_bad++; $display("FAIL lui_r2: got %h want %h", gr(2), 32'habcd0000); end
        $display("test_lui done");
    endtask

    task automatic test_mult();
        clear_prog();
        prog[0]  = i_ins(6'h0F, 0, 1, 16'd1);
        prog[1]  = r_ins(1, 1, 0, 6'h19);
        prog[2]  = r_ins(0, 0, 2, 6'h10);
        prog[3]  = r_ins(0, 0, 3, 6'h12);
        prog[4]  = i_ins(6'h09, 0, 4, 16'hffff);
        prog[5]  = i_ins(6'h0D, 0, 5, 16'd2);
        prog[6]  = r_ins(4, 5, 0, 6'h18);
        prog[7]  = r_ins(0, 0, 6, 6'h10);
        prog[8]  = r_ins(0, 0, 7, 6'h12);
        prog[9]  = r_ins(4, 5, 0, 6'h19);
        prog[10] = r_ins(0, 0, 8, 6'h10);
        prog[11] = r_ins(0, 0, 9, 6'h12);
        prog[12] = HALT;
        boot(1'b0);
        run(14);
        n_cmp++; if (gr(2) !== 32'd1) begin n_bad++; $display("FAIL multu_hi: got %h want %h", gr(2), 32'd1); end
        n_cmp++; if (gr(3) !== 32'd0) begin n_bad++; $display("FAIL multu_lo: got %h want %h", gr(3), 32'd0); end
        n_cmp++; if (gr(6) !== 32'hffffffff) begin n_bad++; $display("FAIL mult_neg_hi: got %h want %h", gr(6), 32'hffffffff); end
        n_cmp++; if (gr(7) !== 32'hfffffffe) begin n_bad++; $display("FAIL mult_neg_lo: got %h want %h", gr(7), 32'hfffffffe); end
        n_cmp++; if (gr(8) !== 32'd1) begin n_bad++; $display("FAIL multu_big_hi: got %h want %h", gr(8), 32'd1); end
        n_cmp++; if (gr(9) !== 32'hfffffffe) begin n_bad++; $display("FAIL multu_big_lo: got %h want %h", gr(9), 32'hfffffffe); end
        n_cmp++; if (gr(10) !== PRE) begin n_bad++; $display("FAIL mult_no_gpr_write: got %h want %h", gr(10), PRE); end
        $display("test_mult done");
    endtask

    // Runs after test_mult so HI/LO hold nonzero values going into reset
    task automatic test_reset();
        clear_prog();
        prog[0] = r_ins(0, 0, 1, 6'h10);
        prog[1] = r_ins(0, 0, 2, 6'h12);
        prog[2] = HALT;
        boot(1'b0);
        n_cmp++; if (gr(1) !== PRE) begin n_bad++; $display("FAIL reset_gpr_kept: got %h want %h", gr(1), PRE); end
        run(3);
        n_cmp++; if (gr(1) !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h want %h", gr(1), 32'd0); end
        n_cmp++; if (gr(2) !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h want %h", gr(2), 32'd0); end
        n_cmp++; if (gr(3) !== PRE) begin n_bad++; $display("FAIL reset_r3_kept: got %h want %h", gr(3), PRE); end
        $display("test_reset done");
    endtask

    task automatic test_jal();
        clear_prog();
        prog[0] = j_ins(6'h03, 26'd3);
        prog[1] = i_ins(6'h0D, 0, 4, 16'd9);
        prog[2] = j_ins(6'h02, 26'd2);
        prog[3] = i_ins(6'h0D, 0, 2, 16'd7);
        prog[4] = r_ins(31, 0, 0, 6'h08);
        boot(1'b0);
        run(1);
        n_cmp++; if (gr(31) !== 32'd4) begin n_bad++; $display("FAIL jal_link: got %h want %h", gr(31), 32'd4); end
        run(2);
        n_cmp++; if (gr(2) !== 32'd7) begin n_bad++; $display("FAIL jal_target: got %h want %h", gr(2), 32'd7); end
        n_cmp++; if (gr(4) !== PRE) begin n_bad++; $display("FAIL jal_skip: got %h want %h", gr(4), PRE); end
        run(3);
        n_cmp++; if (gr(4) !== 32'd9) begin n_bad++; $display("FAIL jr_return: got %h want %h", gr(4), 32'd9); end
        n_cmp++; if (gr(31) !== 32'd4) begin n_bad++; $display("FAIL jal_link_kept: got %h want %h", gr(31), 32'd4); end
        $display("test_jal done");
    endtask

    task automatic test_fib();
        int n;
        logic [31:0] fa, fb, ft;
        n = $urandom_range(5, 15);
        fa = 32'd0;
        fb = 32'd1;
        for (int i = 0; i < n; i++) begin
            ft = fa + fb;
            fa = fb;
            fb = ft;
        end
        clear_prog();
        prog[0]  = i_ins(6'h0D, 0, 1, 16'd0);
        prog[1]  = i_ins(6'h0D, 0, 2, 16'd1);
        prog[2]  = i_ins(6'h0D, 0, 3, 16'(n));
        prog[3]  = i_ins(6'h0D, 0, 5, 16'd1);
        prog[4]  = r_ins(1, 2, 4, 6'h21);
        prog[5]  = r_ins(2, 0, 1, 6'h21);
        prog[6]  = r_ins(4, 0, 2, 6'h21);
        prog[7]  = r_ins(3, 5, 3, 6'h23);
        prog[8]  = i_ins(6'h05, 3, 0, 16'hfffb);
        prog[9]  = i_ins(6'h2B, 0, 1, 16'd8);
        prog[10] = i_ins(6'h23, 0, 6, 16'd8);
        prog[11] = r_ins(1, 2, 0, 6'h21);
        prog[12] = r_ins(0, 0, 8, 6'h25);
        prog[13] = HALT;
        boot(1'b0);
        run(8 + 5 * n + 4);
        n_cmp++; if (gr(1) !== fa) begin n_bad++; $display("FAIL fib_n%0d_a: got %h want %h", n, gr(1), fa); end
        n_cmp++; if (gr(2) !== fb) begin n_bad++; $display("FAIL fib_n%0d_b: got %h want %h", n, gr(2), fb); end
        n_cmp++; if (gr(3) !== 32'd0) begin n_bad++; $display("FAIL fib_count: got %h want %h", gr(3), 32'd0); end
        n_cmp++; if (gr(6) !== fa) begin n_bad++; $display("FAIL fib_sw_lw: got %h want %h", gr(6), fa); end
        n_cmp++; if (gr(8) !== 32'd0) begin n_bad++; $display("FAIL fib_r0_reads_zero: got %h want %h", gr(8), 32'd0); end
        n_cmp++; if (gr(7) !== PRE) begin n_bad++; $display("FAIL fib_untouched: got %h want %h", gr(7), PRE); end
        $display("test_fib n=%0d done", n);
    endtask

    task automatic test_random();
        bit          written [64];
        int          k, rs, rt, rd, idx;
        logic [15:0] imm;
        logic [5:0]  ops [9];
        logic [5:0]  fns [9];
        ops = '{6'h09, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h0A, 6'h0B, 6'h09, 6'h0D};
        fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2B, 6'h18, 6'h19, 6'h10, 6'h12};
        for (int round = 0; round < 8; round++) begin
            clear_prog();
            for (int i = 0; i < 64; i++) written[i] = 1'b0;
            for (int i = 0; i < 24; i++) begin
                k   = $urandom_range(0, 20);
                rs  = $urandom_range(0, 31);
                rt  = $urandom_range(0, 31);
                rd  = $urandom_range(0, 31);
                imm = 16'($urandom);
                idx = $urandom_range(0, 63);
                if (k < 9) begin
                    prog[i] = r_ins(rs, rt, rd, fns[k]);
                end else if (k < 18) begin
                    prog[i] = i_ins(ops[k - 9], rs, rt, imm);
                end else if (k < 20 || !written[idx]) begin
                    prog[i] = i_ins(6'h2B, 0, rt, 16'(idx * 4));
                    written[idx] = 1'b1;
                end else begin
                    prog[i] = i_ins(6'h23, 0, rt, 16'(idx * 4));
                end
            end
            prog[24] = HALT;
            boot(1'b1);
            run(26);
            for (int s = 0; s < 24; s++) model_step();
            for (int i = 1; i < 32; i++) begin
                n_cmp++;
                if (gr(i) !== m_reg[i]) begin
                    n_bad++;
                    $display("FAIL random_round%0d r%0d: got %h want %h", round, i, gr(i), m_reg[i]);
                end
            end
            $display("test_random round %0d done", round);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_alu();
        test_lui();
        test_mult();
        test_reset();
        test_jal();
        test_fib();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
